iic_bus_arbiter: RTL and testbench
==================================

Name: iic_bus_arbiter

Overview:
- Shares the single iic_drive instance among N_REQ requesters: register-init sequencer, runtime config writer, status poller.
- Grants requests round-robin and presents the winner's transaction to iic_drive.
- iic_drive runs on the slow clk_i, so this block stretches the start pulse across that domain and tracks busy/err until the transfer ends.
- Returns done, err and read data to the owning requester.
- Sits between the requesters and iic_drive in the I2C top level.

Parameters:
- N_REQ, 3: number of requesters, valid range 2..8.
- START_TMO, 400: clk_8m cycles to wait for drv_busy to rise after drv_start is asserted (one clk_i period is 20 clk_8m cycles).
- XFER_TMO, 8000: clk_8m cycles allowed for drv_busy to stay high before the transfer is aborted as an error.

Ports:
- clk_8m in 1: system clock.
- rst_n in 1: asynchronous, active-low reset.
- req in N_REQ: level request per requester; hold until req_ack.
- req_wr_rd in N_REQ: per requester, 0 = write, 1 = read.
- req_dev_addr in 8*N_REQ: device address; requester i uses bits [8i+7:8i].
- req_reg in 16*N_REQ: register address.
- req_wdata in 8*N_REQ: write byte.
- req_ack out N_REQ: one-cycle pulse when requester i is granted and its fields are latched.
- req_done out N_REQ: one-cycle pulse when requester i's transaction ends.
- req_err out 1: error flag, valid in the cycle req_done pulses.
- rd_data out 8: read byte, valid in the cycle req_done pulses for a read.
- arb_busy out 1: high from grant to done.
- cur_owner out 3: index of the granted requester; holds its last value when idle.
- drv_start out 1: start_en to iic_drive.
- drv_wr_rd out 1: wr_rd_flag to iic_drive.
- drv_dev_addr out 8: i2c_device_addr to iic_drive.
- drv_reg out 16: register to iic_drive.
- drv_wdata out 8: data_byte to iic_drive.
- drv_busy in 1: busy from iic_drive (clk_i domain).
- drv_err in 1: err from iic_drive (clk_i domain).
- drv_rd_data in 8: read byte from iic_drive; stable while drv_busy is low.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, round-robin pointer = 0, synchronizers cleared. Asserting reset mid-transfer drops drv_start immediately; no req_done is issued.
- Synchronization: drv_busy and drv_err each pass through 2 flops on clk_8m. busy_s is the synchronized busy.
- States: IDLE, GRANT, LAUNCH, XFER, DONE.
- IDLE:
  - If req is nonzero, select the first set bit at or after the pointer, wrapping modulo N_REQ, then go to GRANT.
  - Requests seen in the same cycle are resolved by the pointer only.
- GRANT (1 cycle):
  - Latch the winner's fields into the drv_* registers.
  - Pulse req_ack[winner]; set cur_owner and arb_busy.
  - Pointer becomes winner+1, wrapping.
  - Go to LAUNCH.
- LAUNCH:
  - drv_start = 1; timer counts up.
  - If busy_s = 1: drv_start = 0, clear timer, go to XFER.
  - If timer reaches START_TMO-1: drv_start = 0, set err, go to DONE.
- XFER:
  - Timer counts up.
  - If busy_s = 0: err = synchronized drv_err, capture rd_data from drv_rd_data on reads, go to DONE.
  - If timer reaches XFER_TMO-1: err = 1, go to DONE. iic_drive is not reset by this block.
- DONE (1 cycle):
  - Pulse req_done[owner] and drive req_err; clear arb_busy.
  - Go to IDLE; a new grant is possible 2 cycles after done.
- drv_* fields stay stable from GRANT until the next GRANT.
- req changes outside IDLE are ignored.
- A request dropped before its ack is simply not granted.
- A request still high after its done is treated as a new transaction.
- Timer is 16 bits and saturates.

Decomposition:
- Shared package iic_pkg: FSM state encoding, default timeout constants, CLK_I_DIV = 20.
- Sub-module iic_rr_pick: combinational round-robin selector (req, pointer -> grant index, valid). Reuse it for any later I2C client arbitration.

Test Plan:
- Single write: req = 3'b001 with dev 0x78, reg 0x3008, wdata 0x82; driver model raises busy for 60 clk_i -> req_ack[0] pulses, drv_start held until busy_s, then req_done[0] with req_err = 0 and drv_reg = 0x3008.
- Contention: req = 3'b111 held continuously -> grant order 0, 1, 2, 0; each ack is preceded by the previous done; there is never more than one grant outstanding.
- Read: req[1] with wr_rd = 1; model returns 0xA5 with err = 0 -> rd_data = 0xA5 and req_err = 0 in the req_done[1] cycle.
- Start timeout: model never raises busy -> drv_start drops after 400 cycles, then req_done with req_err = 1, and the FSM returns to IDLE.
- NACK: model pulses err = 1 with busy -> req_err = 1 at done; the pointer still advances.
- Reset mid-transfer: deassert rst_n in XFER -> drv_start = 0, arb_busy = 0, pointer = 0 immediately; after release, a request of 3'b010 is granted to requester 1.

Source files
------------

// File: rtl/iic_pkg.sv
// Shared I2C definitions: arbiter FSM encoding, timeout defaults and transfer payload.
package iic_pkg;

    localparam int unsigned CLK_I_DIV     = 20;
    localparam int unsigned START_TMO_DEF = 20 * CLK_I_DIV;
    localparam int unsigned XFER_TMO_DEF  = 400 * CLK_I_DIV;
    localparam int unsigned TMR_W         = 16;
    localparam int unsigned OWNER_W       = 3;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_GRANT  = 3'd1,
        ST_LAUNCH = 3'd2,
        ST_XFER   = 3'd3,
        ST_DONE   = 3'd4
    } arb_state_e;

    // One transaction as presented to iic_drive.
    typedef struct packed {
        logic        wr_rd;
        logic [7:0]  dev_addr;
        logic [15:0] reg_addr;
        logic [7:0]  wdata;
    } iic_xfer_t;

    // Saturating timer increment.
    function automatic logic [TMR_W-1:0] tmr_inc(input logic [TMR_W-1:0] t);
        return (&t) ? t : t + TMR_W'(1);
    endfunction

endpackage

// File: rtl/iic_rr_pick.sv
// Combinational round-robin selector: first set request at or after ptr, wrapping.
module iic_rr_pick
    import iic_pkg::*;
#(
    parameter int unsigned N_REQ = 3,
    parameter int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic [PTR_W-1:0] grant_c,
    output logic             valid_c
);

    int unsigned idx;

    // Scan from farthest to nearest so the nearest set bit wins.
    always_comb begin
        grant_c = '0;
        valid_c = 1'b0;
        idx     = 0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = (32'(ptr) + 32'(k)) % N_REQ;
            if (req[PTR_W'(idx)]) begin
                grant_c = PTR_W'(idx);
                valid_c = 1'b1;
            end
        end
    end

endmodule

// File: rtl/iic_bus_arbiter.sv
// Round-robin arbiter sharing one iic_drive among N_REQ requesters, with
// start stretching into the slow clk_i domain and busy/err tracking.
module iic_bus_arbiter
    import iic_pkg::*;
#(
    parameter int unsigned N_REQ     = 3,
    parameter int unsigned START_TMO = START_TMO_DEF,
    parameter int unsigned XFER_TMO  = XFER_TMO_DEF
) (
    input  logic                 clk_8m,
    input  logic                 rst_n,
    input  logic [N_REQ-1:0]     req,
    input  logic [N_REQ-1:0]     req_wr_rd,
    input  logic [8*N_REQ-1:0]   req_dev_addr,
    input  logic [16*N_REQ-1:0]  req_reg,
    input  logic [8*N_REQ-1:0]   req_wdata,
    output logic [N_REQ-1:0]     req_ack,
    output logic [N_REQ-1:0]     req_done,
    output logic                 req_err,
    output logic [7:0]           rd_data,
    output logic                 arb_busy,
    output logic [OWNER_W-1:0]   cur_owner,
    output logic                 drv_start,
    output logic                 drv_wr_rd,
    output logic [7:0]           drv_dev_addr,
    output logic [15:0]          drv_reg,
    output logic [7:0]           drv_wdata,
    input  logic                 drv_busy,
    input  logic                 drv_err,
    input  logic [7:0]           drv_rd_data
);

    localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    arb_state_e         state_q, state_d;
    logic               busy_meta, busy_s, err_meta, err_s;
    logic [PTR_W-1:0]   ptr_q, ptr_d, pick_c;
    logic               pick_valid_c;
    logic [TMR_W-1:0]   tmr_q, tmr_d;
    iic_xfer_t          fld_c [N_REQ];
    iic_xfer_t          xfer_q, xfer_d;
    logic [OWNER_W-1:0] owner_q, owner_d;
    logic [N_REQ-1:0]   ack_q, ack_d, done_q, done_d;
    logic               err_q, err_d;
    logic               arb_busy_q, arb_busy_d;
    logic               start_q, start_d;
    logic [7:0]         rd_q, rd_d;

    // Unpack the flat requester buses into per-requester payloads.
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_fld
        assign fld_c[gi] = '{wr_rd:    req_wr_rd[gi],
                             dev_addr: req_dev_addr[8*gi +: 8],
                             reg_addr: req_reg[16*gi +: 16],
                             wdata:    req_wdata[8*gi +: 8]};
    end

    iic_rr_pick #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_pick (
        .req     (req),
        .ptr     (ptr_q),
        .grant_c (pick_c),
        .valid_c (pick_valid_c)
    );

    // Two-flop synchronizers for the clk_i-domain status.
    always_ff @(posedge clk_8m or negedge rst_n) begin
        if (!rst_n) begin
            busy_meta <= 1'b0;
            busy_s    <= 1'b0;
            err_meta  <= 1'b0;
            err_s     <= 1'b0;
        end else begin
            busy_meta <= drv_busy;
            busy_s    <= busy_meta;
            err_meta  <= drv_err;
            err_s     <= err_meta;
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        tmr_d      = tmr_q;
        xfer_d     = xfer_q;
        owner_d    = owner_q;
        ack_d      = '0;
        done_d     = '0;
        err_d      = 1'b0;
        arb_busy_d = arb_busy_q;
        start_d    = 1'b0;
        rd_d       = rd_q;

        case (state_q)
            ST_IDLE: begin
                if (pick_valid_c) begin
                    state_d    = ST_GRANT;
                    xfer_d     = fld_c[pick_c];
                    owner_d    = OWNER_W'(pick_c);
                    ack_d      = N_REQ'(1) << pick_c;
                    arb_busy_d = 1'b1;
                    ptr_d      = (32'(pick_c) == N_REQ - 1) ? '0 : pick_c + PTR_W'(1);
                end
            end
            ST_GRANT: begin
                state_d = ST_LAUNCH;
                start_d = 1'b1;
                tmr_d   = '0;
            end
            ST_LAUNCH: begin
                tmr_d = tmr_inc(tmr_q);
                if (busy_s) begin
                    state_d = ST_XFER;
                    tmr_d   = '0;
                end else if (tmr_q == TMR_W'(START_TMO - 1)) begin
                    state_d = ST_DONE;
                    err_d   = 1'b1;
                    done_d  = N_REQ'(1) << owner_q;
                end else begin
                    start_d = 1'b1;
                end
            end
            ST_XFER: begin
                tmr_d = tmr_inc(tmr_q);
                if (!busy_s) begin
                    state_d = ST_DONE;
                    err_d   = err_s;
                    done_d  = N_REQ'(1) << owner_q;
                    if (xfer_q.wr_rd) begin
                        rd_d = drv_rd_data;
                    end
                end else if (tmr_q == TMR_W'(XFER_TMO - 1)) begin
                    // Driver is left running; it is not ours to reset.
                    state_d = ST_DONE;
                    err_d   = 1'b1;
                    done_d  = N_REQ'(1) << owner_q;
                end
            end
            ST_DONE: begin
                state_d    = ST_IDLE;
                arb_busy_d = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_8m or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            ptr_q      <= '0;
            tmr_q      <= '0;
            xfer_q     <= '0;
            owner_q    <= '0;
            ack_q      <= '0;
            done_q     <= '0;
            err_q      <= 1'b0;
            arb_busy_q <= 1'b0;
            start_q    <= 1'b0;
            rd_q       <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            tmr_q      <= tmr_d;
            xfer_q     <= xfer_d;
            owner_q    <= owner_d;
            ack_q      <= ack_d;
            done_q     <= done_d;
            err_q      <= err_d;
            arb_busy_q <= arb_busy_d;
            start_q    <= start_d;
            rd_q       <= rd_d;
        end
    end

    assign req_ack      = ack_q;
    assign req_done     = done_q;
    assign req_err      = err_q;
    assign rd_data      = rd_q;
    assign arb_busy     = arb_busy_q;
    assign cur_owner    = owner_q;
    assign drv_start    = start_q;
    assign drv_wr_rd    = xfer_q.wr_rd;
    assign drv_dev_addr = xfer_q.dev_addr;
    assign drv_reg      = xfer_q.reg_addr;
    assign drv_wdata    = xfer_q.wdata;

endmodule

// File: tb/tb_iic_bus_arbiter.sv
// Directed bench for iic_bus_arbiter with a small clk_i-paced iic_drive model.
`timescale 1ns/1ps
module tb_iic_bus_arbiter;

    logic        clk_8m = 1'b0;
    logic        rst_n  = 1'b0;
    logic [2:0]  req, req_wr_rd;
    logic [23:0] req_dev_addr;
    logic [47:0] req_reg;
    logic [23:0] req_wdata;
    logic [2:0]  req_ack, req_done;
    logic        req_err, arb_busy, drv_start, drv_wr_rd;
    logic [7:0]  rd_data, drv_dev_addr, drv_wdata;
    logic [2:0]  cur_owner;
    logic [15:0] drv_reg;
    logic        drv_busy;
    logic        drv_err     = 1'b0;
    logic [7:0]  drv_rd_data = 8'h00;

    int checks = 0;
    int passes = 0;
    int fails  = 0;
    int outstanding = 0;

    // iic_drive model state
    int unsigned div_cnt = 0;
    int unsigned m_cnt   = 0;
    logic        m_busy  = 1'b0;
    logic        model_respond;
    logic        model_err;
    logic [7:0]  model_rdata;
    int unsigned model_len;

    iic_bus_arbiter dut (
        .clk_8m       (clk_8m),
        .rst_n        (rst_n),
        .req          (req),
        .req_wr_rd    (req_wr_rd),
        .req_dev_addr (req_dev_addr),
        .req_reg      (req_reg),
        .req_wdata    (req_wdata),
        .req_ack      (req_ack),
        .req_done     (req_done),
        .req_err      (req_err),
        .rd_data      (rd_data),
        .arb_busy     (arb_busy),
        .cur_owner    (cur_owner),
        .drv_start    (drv_start),
        .drv_wr_rd    (drv_wr_rd),
        .drv_dev_addr (drv_dev_addr),
        .drv_reg      (drv_reg),
        .drv_wdata    (drv_wdata),
        .drv_busy     (drv_busy),
        .drv_err      (drv_err),
        .drv_rd_data  (drv_rd_data)
    );

    always #62.5 clk_8m = ~clk_8m;

    // Driver model: acts only on clk_i edges (every 20 clk_8m cycles).
    always @(posedge clk_8m) begin
        if (div_cnt == 19) begin
            div_cnt <= 0;
            if (!m_busy) begin
                if (drv_start && model_respond) begin
                    m_busy  <= 1'b1;
                    m_cnt   <= model_len;
                    drv_err <= model_err;
                end
            end else if (m_cnt <= 1) begin
                m_busy      <= 1'b0;
                drv_rd_data <= model_rdata;
            end else begin
                m_cnt <= m_cnt - 1;
            end
        end else begin
            div_cnt <= div_cnt + 1;
        end
    end
    assign drv_busy = m_busy;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic wr, input logic [7:0] dev,
                           input logic [15:0] rg, input logic [7:0] wd);
        req_wr_rd[i]          = wr;
        req_dev_addr[8*i +: 8] = dev;
        req_reg[16*i +: 16]    = rg;
        req_wdata[8*i +: 8]    = wd;
    endtask

    task automatic wait_ack(input logic [2:0] exp, input string tag, output int cyc);
        cyc = 0;
        while (req_ack == 3'b000 && cyc < 20000) begin
            @(negedge clk_8m);
            cyc++;
        end
        chk(tag, 32'(req_ack), 32'(exp));
    endtask

    task automatic wait_done(input logic [2:0] exp, input string tag);
        int cyc;
        cyc = 0;
        while (req_done == 3'b000 && cyc < 20000) begin
            @(negedge clk_8m);
            cyc++;
        end
        chk(tag, 32'(req_done), 32'(exp));
    endtask

    // Grants must never overlap: each ack needs the previous done first.
    always @(negedge clk_8m) begin
        if (!rst_n) begin
            outstanding = 0;
        end else begin
            if (req_ack != 3'b000) begin
                chk("one_outstanding", 32'(outstanding), 32'd0);
                outstanding++;
            end
            if (req_done != 3'b000) outstanding--;
        end
    end

    initial begin
        #12_500_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cyc;
        int n;
        req = '0; req_wr_rd = '0; req_dev_addr = '0; req_reg = '0; req_wdata = '0;
        model_respond = 1'b1; model_err = 1'b0; model_rdata = 8'h00; model_len = 5;

        repeat (3) @(negedge clk_8m);
        chk("rst_ack",   32'(req_ack),   32'd0);
        chk("rst_done",  32'(req_done),  32'd0);
        chk("rst_busy",  32'(arb_busy),  32'd0);
        chk("rst_start", 32'(drv_start), 32'd0);
        chk("rst_owner", 32'(cur_owner), 32'd0);
        chk("rst_rd",    32'(rd_data),   32'd0);
        rst_n = 1'b1;
        @(negedge clk_8m);

        // Contention: all three held, expect 0,1,2,0 with a 2-cycle done->ack gap
        set_req(0, 1'b0, 8'h10, 16'h0100, 8'h11);
        set_req(1, 1'b0, 8'h20, 16'h0200, 8'h22);
        set_req(2, 1'b0, 8'h30, 16'h0300, 8'h33);
        req = 3'b111;
        wait_ack(3'b001, "c0_ack", cyc);
        chk("c0_reg", 32'(drv_reg), 32'h0100);
        wait_done(3'b001, "c0_done");
        wait_ack(3'b010, "c1_ack", cyc);
        chk("c1_gap", 32'(cyc), 32'd2);
        chk("c1_owner", 32'(cur_owner), 32'd1);
        chk("c1_reg", 32'(drv_reg), 32'h0200);
        wait_done(3'b010, "c1_done");
        wait_ack(3'b100, "c2_ack", cyc);
        chk("c2_gap", 32'(cyc), 32'd2);
        chk("c2_dev", 32'(drv_dev_addr), 32'h30);
        wait_done(3'b100, "c2_done");
        wait_ack(3'b001, "c3_ack", cyc);
        chk("c3_gap", 32'(cyc), 32'd2);
        req = 3'b000;
        wait_done(3'b001, "c3_done");
        @(negedge clk_8m);
        chk("c_idle_busy", 32'(arb_busy), 32'd0);

        // Single write
        model_len = 60;
        set_req(0, 1'b0, 8'h78, 16'h3008, 8'h82);
        req = 3'b001;
        wait_ack(3'b001, "w_ack", cyc);
        req = 3'b000;
        chk("w_owner",  32'(cur_owner),    32'd0);
        chk("w_arb",    32'(arb_busy),     32'd1);
        chk("w_dev",    32'(drv_dev_addr), 32'h78);
        chk("w_reg",    32'(drv_reg),      32'h3008);
        chk("w_wdata",  32'(drv_wdata),    32'h82);
        chk("w_wr_rd",  32'(drv_wr_rd),    32'd0);
        @(negedge clk_8m);
        chk("w_start", 32'(drv_start), 32'd1);
        n = 0;
        while (drv_start && n < 1000) begin
            @(negedge clk_8m);
            n++;
        end
        chk("w_start_held_to_busy", 32'(drv_busy), 32'd1);
        wait_done(3'b001, "w_done");
        chk("w_err", 32'(req_err), 32'd0);
        chk("w_reg_hold", 32'(drv_reg), 32'h3008);

        // Read
        model_len = 8; model_rdata = 8'hA5;
        set_req(1, 1'b1, 8'h78, 16'h300A, 8'h00);
        req = 3'b010;
        wait_ack(3'b010, "r_ack", cyc);
        req = 3'b000;
        chk("r_wr_rd", 32'(drv_wr_rd), 32'd1);
        wait_done(3'b010, "r_done");
        chk("r_data", 32'(rd_data), 32'hA5);
        chk("r_err",  32'(req_err), 32'd0);

        // Start timeout: model never answers
        model_respond = 1'b0;
        set_req(2, 1'b0, 8'h78, 16'h3100, 8'h55);
        req = 3'b100;
        wait_ack(3'b100, "t_ack", cyc);
        req = 3'b000;
        @(negedge clk_8m);
        n = 0;
        while (drv_start && n < 1000) begin
            n++;
            @(negedge clk_8m);
        end
        chk("t_start_cycles", 32'(n), 32'd400);
        chk("t_done", 32'(req_done), 32'(3'b100));
        chk("t_err",  32'(req_err),  32'd1);
        @(negedge clk_8m);
        chk("t_idle", 32'(arb_busy), 32'd0);
        model_respond = 1'b1;

        // NACK
        model_err = 1'b1; model_len = 6;
        set_req(0, 1'b0, 8'h78, 16'h3010, 8'h01);
        req = 3'b001;
        wait_ack(3'b001, "n_ack", cyc);
        req = 3'b000;
        wait_done(3'b001, "n_done");
        chk("n_err", 32'(req_err), 32'd1);
        model_err = 1'b0; model_len = 60;

        // Pointer advanced past 0, so 3'b011 goes to requester 1
        set_req(1, 1'b0, 8'h78, 16'h3020, 8'h02);
        req = 3'b011;
        wait_ack(3'b010, "n_ptr_ack", cyc);
        req = 3'b000;

        // Reset while in XFER
        @(negedge clk_8m);
        n = 0;
        while (drv_start && n < 1000) begin
            @(negedge clk_8m);
            n++;
        end
        repeat (10) @(negedge clk_8m);
        model_len = 5;
        chk("x_busy_pre", 32'(arb_busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("x_start", 32'(drv_start), 32'd0);
        chk("x_arb",   32'(arb_busy),  32'd0);
        chk("x_owner", 32'(cur_owner), 32'd0);
        repeat (3) @(negedge clk_8m);
        rst_n = 1'b1;
        n = 0;
        cyc = 0;
        while (m_busy && n < 5000) begin
            @(negedge clk_8m);
            if (req_done != 3'b000) cyc++;
            n++;
        end
        chk("x_no_done", 32'(cyc), 32'd0);
        set_req(2, 1'b0, 8'h78, 16'h3200, 8'h03);
        req = 3'b110;
        wait_ack(3'b010, "x_ptr_ack", cyc);
        req = 3'b000;
        chk("x_reg", 32'(drv_reg), 32'h3020);
        wait_done(3'b010, "x_done");
        chk("x_err", 32'(req_err), 32'd0);

        repeat (2) @(negedge clk_8m);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
